// File: rtl/swervolf_branch_stats.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_branch_stats
// Brief    : Retired-branch statistics block. Three saturating 32-bit
//            counters (total, taken, mispredicted) behind a small Wishbone
//            register slave, plus a periodic snapshot of the total and taken
//            counts for a seven-segment display.
// Revision : 1.0 - initial release
// ============================================================================
module swervolf_branch_stats #(
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_br_valid,
  input  logic        i_br_taken,
  input  logic        i_br_mispred,
  input  logic [3:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic [31:0] o_branches,
  output logic [31:0] o_taken,
  output logic        o_snap_stb
);

  // Register word selects (adr[3:2])
  localparam logic [1:0]  C_SEL_CTRL    = 2'd0;
  localparam logic [1:0]  C_SEL_TOTAL   = 2'd1;
  localparam logic [1:0]  C_SEL_TAKEN   = 2'd2;
  localparam logic [1:0]  C_SEL_MISPRED = 2'd3;

  // CTRL bit positions
  localparam int          C_BIT_EN      = 0;
  localparam int          C_BIT_CLR     = 1;

  localparam logic [31:0] C_CNT_MAX     = 32'hFFFF_FFFF;

  // The timer counts 0..REFRESH_CYCLES-1; 24 bits cover the largest period.
  localparam int          C_TMR_W       = 24;
  localparam logic [C_TMR_W-1:0] C_TMR_LAST = C_TMR_W'(REFRESH_CYCLES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               r_ack;
  logic [31:0]        r_rdt;
  logic               r_en;
  logic               r_ovf;
  logic [31:0]        r_total;
  logic [31:0]        r_taken;
  logic [31:0]        r_mispred;
  logic [C_TMR_W-1:0] r_tmr;
  logic [31:0]        r_branches_snap;
  logic [31:0]        r_taken_snap;
  logic               r_snap;

  // --------------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------------
  logic               w_req;
  logic               w_ctrl_wr;
  logic               w_clr;
  logic               w_en_next;
  logic               w_ovf_next;
  logic [31:0]        w_total_next;
  logic [31:0]        w_taken_next;
  logic [31:0]        w_mispred_next;
  logic [31:0]        w_rdata;
  logic               w_tmr_wrap;
  logic               w_unused;

  // Only adr[3:2] and CTRL bits [1:0] carry meaning.
  assign w_unused = ^{i_wb_adr[1:0], i_wb_dat[31:2]};

  // Saturating increment: once at all-ones the counter stays there.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc);
    if (inc && (val != C_CNT_MAX)) begin
      return val + 32'd1;
    end
    return val;
  endfunction

  // A new request is only recognised while no ack is outstanding, which
  // spaces back-to-back requests on a held strobe to one per two cycles.
  assign w_req      = i_wb_cyc & i_wb_stb & ~r_ack;
  assign w_ctrl_wr  = w_req & i_wb_we & (i_wb_adr[3:2] == C_SEL_CTRL);
  assign w_clr      = w_ctrl_wr & i_wb_dat[C_BIT_CLR];
  assign w_tmr_wrap = (r_tmr == C_TMR_LAST);

  // Next counter/flag values; clear overrides any same-cycle branch event.
  always_comb begin
    w_en_next      = r_en;
    w_total_next   = r_total;
    w_taken_next   = r_taken;
    w_mispred_next = r_mispred;
    w_ovf_next     = r_ovf;

    if (w_ctrl_wr) begin
      w_en_next = i_wb_dat[C_BIT_EN];
    end

    if (w_clr) begin
      w_total_next   = 32'd0;
      w_taken_next   = 32'd0;
      w_mispred_next = 32'd0;
      w_ovf_next     = 1'b0;
    end else begin
      w_total_next   = sat_inc(r_total,   r_en & i_br_valid);
      w_taken_next   = sat_inc(r_taken,   r_en & i_br_valid & i_br_taken);
      w_mispred_next = sat_inc(r_mispred, r_en & i_br_valid & i_br_mispred);
      w_ovf_next     = r_ovf
                     | (w_total_next   == C_CNT_MAX)
                     | (w_taken_next   == C_CNT_MAX)
                     | (w_mispred_next == C_CNT_MAX);
    end
  end

  // Register read mux, sampled in the request cycle.
  always_comb begin
    w_rdata = 32'd0;
    case (i_wb_adr[3:2])
      C_SEL_CTRL:    w_rdata = {29'd0, r_ovf, 1'b0, r_en};
      C_SEL_TOTAL:   w_rdata = r_total;
      C_SEL_TAKEN:   w_rdata = r_taken;
      C_SEL_MISPRED: w_rdata = r_mispred;
      default:       w_rdata = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential
  // --------------------------------------------------------------------------

  // Counters, enable and overflow flag; written every cycle from next-state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en      <= 1'b0;
      r_ovf     <= 1'b0;
      r_total   <= 32'd0;
      r_taken   <= 32'd0;
      r_mispred <= 32'd0;
    end else begin
      r_en      <= w_en_next;
      r_ovf     <= w_ovf_next;
      r_total   <= w_total_next;
      r_taken   <= w_taken_next;
      r_mispred <= w_mispred_next;
    end
  end

  // Wishbone ack pulse and read data; data is zero whenever ack is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack <= 1'b0;
      r_rdt <= 32'd0;
    end else begin
      r_ack <= w_req;
      r_rdt <= w_req ? w_rdata : 32'd0;
    end
  end

  // Refresh timer and display snapshots; snapshots take pre-increment counts.
  always_ff @(posedge clk) begin
    if (rst || w_clr) begin
      r_tmr           <= '0;
      r_branches_snap <= 32'd0;
      r_taken_snap    <= 32'd0;
      r_snap          <= 1'b0;
    end else if (w_tmr_wrap) begin
      r_tmr           <= '0;
      r_branches_snap <= r_total;
      r_taken_snap    <= r_taken;
      r_snap          <= 1'b1;
    end else begin
      r_tmr           <= r_tmr + C_TMR_W'(1);
      r_snap          <= 1'b0;
    end
  end

  assign o_wb_ack   = r_ack;
  assign o_wb_rdt   = r_rdt;
  assign o_branches = r_branches_snap;
  assign o_taken    = r_taken_snap;
  assign o_snap_stb = r_snap;

endmodule
`default_nettype wire

// File: tb/tb_swervolf_branch_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_swervolf_branch_stats
// Brief    : Directed bench for swervolf_branch_stats. Stimulus pushes the
//            expected Wishbone/snapshot responses into queues; monitors pop
//            and compare whenever the DUT acks or strobes a snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swervolf_branch_stats;

  localparam int unsigned REFRESH = 8;

  logic        clk;
  logic        rst;
  logic        i_br_valid;
  logic        i_br_taken;
  logic        i_br_mispred;
  logic [3:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic [31:0] o_branches;
  logic [31:0] o_taken;
  logic        o_snap_stb;

  swervolf_branch_stats #(.REFRESH_CYCLES(REFRESH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_br_valid   (i_br_valid),
    .i_br_taken   (i_br_taken),
    .i_br_mispred (i_br_mispred),
    .i_wb_adr     (i_wb_adr),
    .i_wb_dat     (i_wb_dat),
    .i_wb_we      (i_wb_we),
    .i_wb_cyc     (i_wb_cyc),
    .i_wb_stb     (i_wb_stb),
    .o_wb_rdt     (o_wb_rdt),
    .o_wb_ack     (o_wb_ack),
    .o_branches   (o_branches),
    .o_taken      (o_taken),
    .o_snap_stb   (o_snap_stb)
  );

  typedef struct packed {
    logic        chk;
    logic [31:0] dat;
  } wb_exp_t;

  typedef struct packed {
    logic [31:0] br;
    logic [31:0] tk;
  } snap_exp_t;

  wb_exp_t   wb_q[$];
  snap_exp_t snap_q[$];

  int checks;
  int errors;
  int cyc_cnt;
  int wr_cyc;

  localparam logic [3:0] A_CTRL    = 4'h0;
  localparam logic [3:0] A_TOTAL   = 4'h4;
  localparam logic [3:0] A_TAKEN   = 4'h8;
  localparam logic [3:0] A_MISPRED = 4'hC;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Wishbone monitor
  always @(negedge clk) begin
    if (o_wb_ack === 1'b1) begin
      if (wb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack with rdt=%08h, required no ack", o_wb_rdt);
      end else begin
        wb_exp_t e;
        e = wb_q.pop_front();
        if (e.chk) begin
          checks++;
          if (o_wb_rdt !== e.dat) begin
            errors++;
            $display("FAIL wb_read: got %08h, required %08h", o_wb_rdt, e.dat);
          end
        end
      end
    end else if (!rst) begin
      checks++;
      if (o_wb_rdt !== 32'd0) begin
        errors++;
        $display("FAIL rdt_idle: got %08h, required 00000000 while ack low", o_wb_rdt);
      end
    end
  end

  // Snapshot monitor
  always @(negedge clk) begin
    if (o_snap_stb === 1'b1 && snap_q.size() != 0) begin
      snap_exp_t s;
      s = snap_q.pop_front();
      checks++;
      if (o_branches !== s.br || o_taken !== s.tk) begin
        errors++;
        $display("FAIL snapshot: got br=%08h tk=%08h, required br=%08h tk=%08h",
                 o_branches, o_taken, s.br, s.tk);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end
  endtask

  task automatic wait_ack(input string name);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk);
      #1;
      if (o_wb_ack) got = 1'b1;
    end
    i_wb_cyc   = 1'b0;
    i_wb_stb   = 1'b0;
    i_wb_we    = 1'b0;
    i_br_valid = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no ack, required ack within 4 cycles", name);
    end
  endtask

  task automatic wb_read(input logic [3:0] adr, input logic [31:0] exp);
    wb_q.push_back('{chk: 1'b1, dat: exp});
    i_wb_adr = adr;
    i_wb_we  = 1'b0;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    wait_ack("read");
    @(posedge clk);
    #1;
  endtask

  // Optional same-cycle branch event alongside the write.
  task automatic wb_write(input logic [3:0] adr, input logic [31:0] dat, input logic br);
    wb_q.push_back('{chk: 1'b0, dat: 32'd0});
    i_wb_adr   = adr;
    i_wb_dat   = dat;
    i_wb_we    = 1'b1;
    i_wb_cyc   = 1'b1;
    i_wb_stb   = 1'b1;
    i_br_valid = br;
    wait_ack("write");
    wr_cyc = cyc_cnt;
  endtask

  task automatic branch(input logic v, input logic t, input logic m);
    i_br_valid   = v;
    i_br_taken   = t;
    i_br_mispred = m;
    @(posedge clk);
    #1;
    i_br_valid   = 1'b0;
    i_br_taken   = 1'b0;
    i_br_mispred = 1'b0;
  endtask

  initial begin
    logic [9:0] v_tk;
    logic [9:0] v_mp;
    logic       found;
    int         t0;
    int         nack;

    checks = 0; errors = 0; cyc_cnt = 0; wr_cyc = 0;
    rst = 1'b1;
    i_br_valid = 1'b0; i_br_taken = 1'b0; i_br_mispred = 1'b0;
    i_wb_adr = 4'h0; i_wb_dat = 32'd0; i_wb_we = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",      {31'd0, o_wb_ack},   32'd0);
    check("rst_rdt",      o_wb_rdt,            32'd0);
    check("rst_branches", o_branches,          32'd0);
    check("rst_taken",    o_taken,             32'd0);
    check("rst_snap",     {31'd0, o_snap_stb}, 32'd0);
    rst = 1'b0;

    // Counting disabled until enabled
    wb_read(A_CTRL, 32'd0);
    repeat (3) branch(1'b1, 1'b1, 1'b1);
    wb_read(A_TOTAL, 32'd0);

    // 10 branches, 6 taken, 2 mispredicted, with unqualified noise
    wb_write(A_CTRL, 32'd1, 1'b0);
    @(posedge clk); #1;
    v_tk = 10'b00_0011_1111;
    v_mp = 10'b01_0100_0000;
    for (int i = 0; i < 10; i++) begin
      branch(1'b1, v_tk[i], v_mp[i]);
      if (i == 4) branch(1'b0, 1'b1, 1'b1);
    end
    branch(1'b0, 1'b1, 1'b1);
    wb_read(A_TOTAL,   32'd10);
    wb_read(A_TAKEN,   32'd6);
    wb_read(A_MISPRED, 32'd2);
    wb_read(A_CTRL,    32'd1);

    // Snapshot period: clear realigns timer, 5 branches (3 taken) before wrap
    wb_write(A_CTRL, 32'd3, 1'b0);
    t0 = wr_cyc;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) branch(1'b1, (i < 3), 1'b0);
    snap_q.push_back('{br: 32'd5, tk: 32'd3});
    snap_q.push_back('{br: 32'd5, tk: 32'd3});
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (o_snap_stb) found = 1'b1;
    end
    check("snap1_found", {31'd0, found}, 32'd1);
    check("snap1_period", cyc_cnt - t0, REFRESH);
    t0 = cyc_cnt;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (o_snap_stb) found = 1'b1;
      else check("snap_stable", o_branches, 32'd5);
    end
    check("snap2_found", {31'd0, found}, 32'd1);
    check("snap2_period", cyc_cnt - t0, REFRESH);
    @(posedge clk); #1;
    wb_read(A_TOTAL, 32'd5);

    // Saturation and sticky overflow
    wb_write(A_CTRL, 32'd0, 1'b0);
    @(posedge clk); #1;
    force dut.r_total = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.r_total;
    wb_write(A_CTRL, 32'd1, 1'b0);
    @(posedge clk); #1;
    repeat (3) branch(1'b1, 1'b0, 1'b0);
    wb_read(A_TOTAL, 32'hFFFF_FFFF);
    wb_read(A_CTRL,  32'd5);
    wb_read(A_TAKEN, 32'd3);

    // Clear with enable in the same cycle as a branch: clear wins
    wb_write(A_CTRL, 32'd3, 1'b1);
    check("clr_branches", o_branches, 32'd0);
    check("clr_taken",    o_taken,    32'd0);
    @(posedge clk); #1;
    wb_read(A_TOTAL, 32'd0);
    wb_read(A_CTRL,  32'd1);

    // Held strobe: one ack every two cycles
    repeat (2) branch(1'b1, 1'b1, 1'b0);
    repeat (3) wb_q.push_back('{chk: 1'b1, dat: 32'd2});
    i_wb_adr = A_TAKEN; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    nack = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (o_wb_ack) nack++;
      @(posedge clk); #1;
    end
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    check("held_stb_acks", nack, 32'd3);
    @(posedge clk); #1;

    // Reset during a pending read
    i_wb_adr = A_TOTAL; i_wb_we = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    check("rstmid_ack",      {31'd0, o_wb_ack},   32'd0);
    check("rstmid_rdt",      o_wb_rdt,            32'd0);
    check("rstmid_branches", o_branches,          32'd0);
    check("rstmid_taken",    o_taken,             32'd0);
    check("rstmid_snap",     {31'd0, o_snap_stb}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (3) branch(1'b1, 1'b1, 1'b1);
    wb_read(A_TOTAL,   32'd0);
    wb_read(A_TAKEN,   32'd0);
    wb_read(A_MISPRED, 32'd0);
    wb_read(A_CTRL,    32'd0);

    repeat (3) @(posedge clk);
    #1;
    check("wb_q_drained", wb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swervolf_branch_stats.md
SWERVOLF_BRANCH_STATS -- requirements
Module: swervolf_branch_stats

Interface
REQ-001 SHALL have parameter REFRESH_CYCLES, default 50000, display snapshot period in clk cycles (legal range 2..2^24).
REQ-002 SHALL have one clock and one reset: clk input 1 (all logic on rising edge); rst input 1 (synchronous, active-high).
REQ-003 i_br_valid  input  1  branch retired this cycle.
REQ-004 i_br_taken  input  1  retired branch was taken; qualified by i_br_valid.
REQ-005 i_br_mispred  input  1  retired branch was mispredicted; qualified by i_br_valid.
REQ-006 i_wb_adr  input  4  Wishbone byte address; bits [3:2] select the register.
REQ-007 i_wb_dat  input  32  write data; i_wb_we input 1; i_wb_cyc input 1; i_wb_stb input 1.
REQ-008 o_wb_rdt  output  32  read data; o_wb_ack  output  1  transfer acknowledge.
REQ-009 o_branches  output  32  snapshot of the total-branch counter, for the seven-segment display.
REQ-010 o_taken  output  32  snapshot of the taken-branch counter.
REQ-011 o_snap_stb  output  1  one-cycle pulse when the snapshots update.

Function
REQ-012 Counters SHALL be TOTAL, TAKEN and MISPRED, each 32 bits, and each SHALL saturate at 0xFFFFFFFF (no wrap).
REQ-013 While CTRL.en=1, i_br_valid SHALL increment TOTAL, i_br_valid&i_br_taken SHALL increment TAKEN, and i_br_valid&i_br_mispred SHALL increment MISPRED, each by exactly 1 per cycle.
REQ-014 i_br_taken or i_br_mispred without i_br_valid SHALL be ignored.
REQ-015 While CTRL.en=0, all counters SHALL hold their values.
REQ-016 Any counter reaching saturation SHALL set sticky CTRL.ovf (bit 2), cleared only by clear or by reset.
REQ-017 Register map (word select adr[3:2]):
- 0 CTRL: bit0 en RW, bit1 clr W (self-clearing, reads 0), bit2 ovf RO; other bits read 0.
- 1 TOTAL RO.
- 2 TAKEN RO.
- 3 MISPRED RO.
REQ-018 Writes to RO registers SHALL have no effect but SHALL still be acknowledged.
REQ-019 Clear SHALL zero all three counters and ovf on the cycle after the write is accepted.
REQ-020 If a clear and a branch event occur in the same cycle, clear SHALL win; the event is dropped and counters read 0.
REQ-021 Wishbone handshake:
- o_wb_ack SHALL assert exactly one cycle after the cycle in which i_wb_cyc&i_wb_stb&~o_wb_ack is first seen.
- o_wb_ack SHALL be high for one cycle only.
- A continuously held stb SHALL therefore produce at most one ack every 2 cycles.
REQ-022 o_wb_rdt SHALL be valid while o_wb_ack=1 and SHALL hold register contents sampled in the request cycle; it SHALL be 0 otherwise.
REQ-023 Refresh timer:
- counts 0..REFRESH_CYCLES-1 and wraps to 0.
- on the wrap cycle, o_branches<=TOTAL, o_taken<=TAKEN, and o_snap_stb=1 for that one cycle.
- the timer runs regardless of CTRL.en.
REQ-024 If a snapshot and a counter increment coincide, the snapshot SHALL capture the pre-increment value.
REQ-025 A clear SHALL also reset the refresh timer to 0 and zero o_branches/o_taken in the same cycle as the counters.
REQ-026 Counter increments SHALL be visible on a Wishbone read issued the cycle after the event (1-cycle latency).

Reset
REQ-027 On rst=1 at a clock edge:
- all counters, ovf, en, refresh timer, o_branches and o_taken SHALL be 0.
- o_snap_stb=0, o_wb_ack=0, o_wb_rdt=0.
REQ-028 rst asserted mid-transfer SHALL abort the pending ack; the first ack after reset SHALL come only from a new request.
REQ-029 After rst deasserts, counting SHALL be disabled until software sets CTRL.en=1.

Verification
REQ-030 Reset, write CTRL=1, drive 10 valid branches (6 taken, 2 mispred) -> read TOTAL=10, TAKEN=6, MISPRED=2.
REQ-031 REFRESH_CYCLES=8 with 5 branches before the timer wraps -> o_snap_stb pulses every 8 cycles, o_branches=5 after the first pulse, stable between pulses.
REQ-032 Force TOTAL to 0xFFFFFFFE, apply 3 valid branches -> TOTAL=0xFFFFFFFF, CTRL reads 0x5.
REQ-033 Write CTRL=3 in the same cycle as i_br_valid=1 -> next cycle TOTAL=0, ovf=0, o_branches=0, en=1.
REQ-034 Hold stb/cyc high for 6 cycles reading TAKEN -> exactly 3 single-cycle acks, o_wb_rdt=0 between acks.
REQ-035 Assert rst during a pending read with en=1 and counts nonzero -> no ack, all outputs 0, and 0 counts while en=0.
